// File: rtl/pulse_stretcher_if.sv
// Tick-side interface of pulse_stretcher: the producer drives tick/len,
// the stretcher returns the stretched level plus busy/overrun status.
interface pulse_stretcher_if #(
  parameter int WIDTH = 8
);
  logic             tick;
  logic [WIDTH-1:0] len;
  logic             lvl;
  logic             busy;
  logic             overrun;

  modport master (
    output tick,
    output len,
    input  lvl,
    input  busy,
    input  overrun
  );

  modport slave (
    input  tick,
    input  len,
    output lvl,
    output busy,
    output overrun
  );
endinterface

// File: rtl/pulse_stretcher.sv
// pulse_stretcher: turns single-cycle ticks into level pulses of
// max(len,1) cycles separated by at least GAP low cycles. One tick can wait
// in a pending slot while a pulse or gap runs; a further tick is dropped and
// flagged on overrun.
// Optional feature: define PULSE_STRETCHER_RETRIG_EN to make a tick during
// the high phase restart the length count instead of queueing.
module pulse_stretcher #(
  parameter int WIDTH = 8,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  pulse_stretcher_if.slave   bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] GAP_M1   = WIDTH'(GAP - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic             pend_q, pend_d;
  logic             overrun_d;
  logic             lvl_q;
  logic             busy_q;
  logic             overrun_q;
  logic [WIDTH-1:0] len_m1_s;
  logic [1:0]       absorb_s;

  // A tick arriving while busy goes into the pending slot if it is free,
  // otherwise it is dropped. Returns {overrun, pend_next}.
  function automatic logic [1:0] absorb_tick(input logic pend, input logic tick);
    logic [1:0] res;
    if (tick) begin
      res = pend ? 2'b11 : 2'b01;
    end else begin
      res = {1'b0, pend};
    end
    return res;
  endfunction

  // Reload value for a new pulse: a zero length behaves as one cycle.
  always_comb begin
    if (bus.len == CNT_ZERO) begin
      len_m1_s = CNT_ZERO;
    end else begin
      len_m1_s = bus.len - CNT_ONE;
    end
  end

  assign absorb_s = absorb_tick(pend_q, bus.tick);

  // Next-state logic for the IDLE/HIGH/GAP sequencer, counter and pending slot.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_d    = pend_q;
    overrun_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pend_q) begin
          // Serve the slot; a tick on this same edge takes its place.
          state_d = ST_HIGH;
          cnt_d   = len_m1_s;
          pend_d  = bus.tick;
        end else if (bus.tick) begin
          state_d = ST_HIGH;
          cnt_d   = len_m1_s;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HIGH: begin
`ifdef PULSE_STRETCHER_RETRIG_EN
        if (bus.tick) begin
          cnt_d = len_m1_s;
        end else if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_M1;
        end
`else
        if (cnt_q != CNT_ZERO) begin
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_M1;
        end
        overrun_d = absorb_s[1];
        pend_d    = absorb_s[0];
`endif
      end
      ST_GAP: begin
        if (cnt_q != CNT_ZERO) begin
          cnt_d     = cnt_q - CNT_ONE;
          overrun_d = absorb_s[1];
          pend_d    = absorb_s[0];
        end else if (pend_q) begin
          // Pending tick starts the next pulse right after an exact GAP.
          state_d = ST_HIGH;
          cnt_d   = len_m1_s;
          pend_d  = bus.tick;
        end else begin
          // Slot empty: a tick on this edge is parked and served from IDLE.
          state_d = ST_IDLE;
          pend_d  = bus.tick;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
        pend_d  = 1'b0;
      end
    endcase
  end

  // State, counter, pending slot and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      pend_q    <= 1'b0;
      lvl_q     <= 1'b0;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_q    <= pend_d;
      lvl_q     <= (state_d == ST_HIGH);
      busy_q    <= (state_d != ST_IDLE) || pend_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.lvl     = lvl_q;
  assign bus.busy    = busy_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_pulse_stretcher.sv
// Scoreboard bench for pulse_stretcher: two instances (GAP=1 and GAP=2) share
// the same tick/len stimulus. A timeline model (pulse start edge, length,
// pending slot) predicts lvl/busy/overrun after each edge; a monitor on the
// falling edge pops and compares.
module tb_pulse_stretcher;
  localparam int W = 8;

  typedef struct packed {
    logic lvl;
    logic busy;
    logic ovr;
  } obs_t;

`ifdef PULSE_STRETCHER_RETRIG_EN
  localparam bit RETRIG = 1'b1;
`else
  localparam bit RETRIG = 1'b0;
`endif

  logic         clk    = 1'b0;
  logic         rst    = 1'b0;
  logic         tick_v = 1'b0;
  logic [W-1:0] len_v  = '0;

  int   total  = 0;
  int   bad    = 0;
  bit   mon_en = 1'b0;
  obs_t q0[$];
  obs_t q1[$];
  obs_t e0;
  obs_t e1;

  // model state per instance
  int gp[2] = '{1, 2};
  int m_t[2];
  int m_s[2];
  int m_l[2];
  bit m_have[2];
  bit m_pend[2];

  always #5 clk = ~clk;

  pulse_stretcher_if #(.WIDTH(W)) bus1 ();
  pulse_stretcher_if #(.WIDTH(W)) bus2 ();

  assign bus1.tick = tick_v;
  assign bus1.len  = len_v;
  assign bus2.tick = tick_v;
  assign bus2.len  = len_v;

  pulse_stretcher #(.WIDTH(W), .GAP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  pulse_stretcher #(.WIDTH(W), .GAP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));

  task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s at %0t: got lvl/busy/ovr=%b want %b", name, $time, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_t[d]    = 0;
      m_s[d]    = 0;
      m_l[d]    = 0;
      m_have[d] = 1'b0;
      m_pend[d] = 1'b0;
    end
  endtask

  // A pulse started at edge s with length L is high after edges s..s+L-1,
  // low through the gap, and its slot frees at edge s+L+GAP.
  task automatic model_step(input int d, input bit tk, input int ln, output obs_t o);
    int t;
    int lv;
    bit started;
    bit ended;
    bit drop;
    t       = m_t[d];
    lv      = (ln == 0) ? 1 : ln;
    started = 1'b0;
    ended   = 1'b0;
    drop    = 1'b0;
    if (m_have[d] && t == m_s[d] + m_l[d] + gp[d]) begin
      m_have[d] = 1'b0;
      ended     = 1'b1;
      if (m_pend[d]) begin
        m_pend[d] = 1'b0;
        m_have[d] = 1'b1;
        m_s[d]    = t;
        m_l[d]    = lv;
        started   = 1'b1;
      end
    end else if (!m_have[d] && m_pend[d]) begin
      m_pend[d] = 1'b0;
      m_have[d] = 1'b1;
      m_s[d]    = t;
      m_l[d]    = lv;
      started   = 1'b1;
    end
    if (tk) begin
      if (!m_have[d] && !ended) begin
        m_have[d] = 1'b1;
        m_s[d]    = t;
        m_l[d]    = lv;
      end else if (RETRIG && m_have[d] && !started && t > m_s[d] && t <= m_s[d] + m_l[d]) begin
        m_s[d] = t;
        m_l[d] = lv;
      end else if (m_pend[d]) begin
        drop = 1'b1;
      end else begin
        m_pend[d] = 1'b1;
      end
    end
    o.lvl  = m_have[d] && t >= m_s[d] && t < m_s[d] + m_l[d];
    o.busy = m_have[d] || m_pend[d];
    o.ovr  = drop;
    m_t[d] = t + 1;
  endtask

  // Drive one cycle of stimulus, then predict the outcome of the edge.
  task automatic cycle(input bit tk, input int ln);
    obs_t o;
    tick_v = tk;
    len_v  = ln[W-1:0];
    @(posedge clk);
    model_step(0, tk, ln, o);
    q0.push_back(o);
    model_step(1, tk, ln, o);
    q1.push_back(o);
    #1;
  endtask

  // Monitor: compare each instance against its expected queue.
  always @(negedge clk) begin
    if (mon_en) begin
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        chk("gap1", {bus1.lvl, bus1.busy, bus1.overrun}, e0);
      end
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        chk("gap2", {bus2.lvl, bus2.busy, bus2.overrun}, e1);
      end
    end
  end

  initial begin
    bit tk;
    int ln;
    model_reset();
    #1;
    chk("reset_gap1", {bus1.lvl, bus1.busy, bus1.overrun}, 3'b000);
    chk("reset_gap2", {bus2.lvl, bus2.busy, bus2.overrun}, 3'b000);
    #13;
    rst    = 1'b1;
    mon_en = 1'b1;

    // single pulse, len=3
    repeat (5) cycle(1'b0, 3);
    cycle(1'b1, 3);
    repeat (8) cycle(1'b0, 3);
    // zero length
    cycle(1'b1, 0);
    repeat (6) cycle(1'b0, 0);
    // pending tick
    cycle(1'b1, 4);
    cycle(1'b0, 4);
    cycle(1'b1, 4);
    repeat (14) cycle(1'b0, 4);
    // overrun
    repeat (3) cycle(1'b1, 4);
    repeat (16) cycle(1'b0, 4);
    // retrigger pattern
    cycle(1'b1, 3);
    cycle(1'b0, 3);
    cycle(1'b1, 3);
    repeat (10) cycle(1'b0, 3);

    // asynchronous reset mid-pulse with a tick pending
    cycle(1'b1, 10);
    cycle(1'b0, 10);
    cycle(1'b1, 10);
    cycle(1'b0, 10);
    #2;
    mon_en = 1'b0;
    rst    = 1'b0;
    q0.delete();
    q1.delete();
    #1;
    chk("async_rst_gap1", {bus1.lvl, bus1.busy, bus1.overrun}, 3'b000);
    chk("async_rst_gap2", {bus2.lvl, bus2.busy, bus2.overrun}, 3'b000);
    @(posedge clk);
    #3;
    chk("rst_hold_gap1", {bus1.lvl, bus1.busy, bus1.overrun}, 3'b000);
    chk("rst_hold_gap2", {bus2.lvl, bus2.busy, bus2.overrun}, 3'b000);
    rst = 1'b1;
    model_reset();
    mon_en = 1'b1;
    repeat (20) cycle(1'b0, 10);

    // back-to-back ticks every cycle
    repeat (40) cycle(1'b1, 2);
    repeat (10) cycle(1'b0, 2);

    // randomized traffic
    repeat (3000) begin
      tk = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0) begin
        ln = $urandom_range(0, 20);
      end else begin
        ln = $urandom_range(0, 5);
      end
      cycle(tk, ln);
    end
    repeat (30) cycle(1'b0, 1);

    @(negedge clk);
    #1;
    total++;
    if (q0.size() + q1.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d expected entries left unchecked, want 0", q0.size() + q1.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
